// File: rtl/ramb4_s1_bit_reader.sv
// ramb4_s1_bit_reader: walks a bit range of a 4096x1 block RAM and presents it as bytes on a valid/ready port
module ramb4_s1_bit_reader #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [11:0] BASE,
    input  logic [9:0]  NBYTES,
    output logic        BUSY,
    output logic        DONE,
    output logic [11:0] RAM_ADDR,
    output logic        RAM_EN,
    output logic        RAM_WE,
    input  logic        RAM_DO,
    output logic [7:0]  DOUT,
    output logic        DOUT_VALID,
    input  logic        DOUT_READY
);
    typedef enum logic [1:0] {IDLE, READ, LAST, PRESENT} state_t;
    state_t      state, state_nxt;
    logic [11:0] addr;
    logic [2:0]  bitcnt;
    logic [9:0]  bytes_left;
    logic [7:0]  shift, shift_nxt, dout;
    logic        dout_valid, done;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START && NBYTES != 10'd0) state_nxt = READ;
            READ:    if (bitcnt == 3'd7) state_nxt = LAST;
            LAST:    state_nxt = PRESENT;
            PRESENT: if (DOUT_READY) state_nxt = bytes_left == 10'd1 ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end
    // RAM_DO always carries the bit of the address issued one cycle earlier
    assign shift_nxt = MSB_FIRST ? {shift[6:0], RAM_DO} : {RAM_DO, shift[7:1]};
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            addr       <= '0;
            bitcnt     <= '0;
            bytes_left <= '0;
            shift      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == IDLE && START && NBYTES == 10'd0) ||
                     (state == PRESENT && DOUT_READY && bytes_left == 10'd1);
            case (state)
                IDLE: if (START) begin
                    addr       <= BASE;
                    bitcnt     <= '0;
                    bytes_left <= NBYTES;
                end
                READ: begin
                    addr   <= addr + 12'd1;
                    bitcnt <= bitcnt + 3'd1;
                    if (bitcnt != 3'd0) shift <= shift_nxt;
                end
                LAST: begin
                    dout       <= shift_nxt;
                    dout_valid <= 1'b1;
                end
                PRESENT: if (DOUT_READY) begin
                    dout_valid <= 1'b0;
                    bytes_left <= bytes_left - 10'd1;
                    bitcnt     <= '0;
                end
                default: ;
            endcase
        end
    end
    assign BUSY       = state != IDLE;
    assign DONE       = done;
    assign RAM_ADDR   = addr;
    assign RAM_EN     = state == READ;
    assign RAM_WE     = 1'b0;
    assign DOUT       = dout;
    assign DOUT_VALID = dout_valid;
endmodule

// File: tb/tb_ramb4_s1_bit_reader.sv
// tb_ramb4_s1_bit_reader: MSB-first and LSB-first readers on identical stimulus, each with its own RAM model,
// checked against byte values computed straight from the memory contents
module tb_ramb4_s1_bit_reader;
    logic        clk = 0, rst = 1, start = 0, ready = 0;
    logic [11:0] base = 0;
    logic [9:0]  nbytes = 0;
    logic        busy0, done0, en0, we0, valid0, do0 = 0;
    logic        busy1, done1, en1, we1, valid1, do1 = 0;
    logic [11:0] addr0, addr1;
    logic [7:0]  dout0, dout1;
    logic        mem [4096];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    ramb4_s1_bit_reader #(.MSB_FIRST(1'b1)) dut0 (
        .CLK(clk), .RST(rst), .START(start), .BASE(base), .NBYTES(nbytes),
        .BUSY(busy0), .DONE(done0), .RAM_ADDR(addr0), .RAM_EN(en0), .RAM_WE(we0),
        .RAM_DO(do0), .DOUT(dout0), .DOUT_VALID(valid0), .DOUT_READY(ready));
    ramb4_s1_bit_reader #(.MSB_FIRST(1'b0)) dut1 (
        .CLK(clk), .RST(rst), .START(start), .BASE(base), .NBYTES(nbytes),
        .BUSY(busy1), .DONE(done1), .RAM_ADDR(addr1), .RAM_EN(en1), .RAM_WE(we1),
        .RAM_DO(do1), .DOUT(dout1), .DOUT_VALID(valid1), .DOUT_READY(ready));

    always @(posedge clk) begin
        if (en0) do0 <= mem[addr0];
        if (en1) do1 <= mem[addr1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int a, input bit msb);
        logic [7:0] b = '0;
        for (int j = 0; j < 8; j++)
            if (msb) b[7-j] = mem[(a + j) % 4096];
            else b[j] = mem[(a + j) % 4096];
        return b;
    endfunction

    task automatic reset_outputs(input string tag);
        check({tag, "_busy"}, {busy0, busy1}, 0);
        check({tag, "_done"}, {done0, done1}, 0);
        check({tag, "_addr"}, {addr0, addr1}, 0);
        check({tag, "_en_we"}, {en0, en1, we0, we1}, 0);
        check({tag, "_dout"}, {dout0, dout1}, 0);
        check({tag, "_valid"}, {valid0, valid1}, 0);
    endtask

    // Called at a falling edge; returns at the falling edge where DONE is seen.
    // ready_mode: 0 always ready, 1 random, 2 stall first byte 5 cycles then ready.
    task automatic run_cmd(input int b, input int n, input int ready_mode, input bit poke,
                           output int first_valid, output int done_cyc);
        int         addrq[$];
        logic [7:0] q0[$], q1[$];
        logic [7:0] hd = 0;
        bit         hold = 0;
        int         stall = 0;
        for (int i = 0; i < 8 * n; i++) addrq.push_back((b + i) % 4096);
        for (int i = 0; i < n; i++) begin
            q0.push_back(ref_byte(b + 8 * i, 1));
            q1.push_back(ref_byte(b + 8 * i, 0));
        end
        start = 1; base = 12'(b); nbytes = 10'(n); ready = (ready_mode == 0);
        @(posedge clk); #1 start = 0;
        first_valid = -1; done_cyc = -1;
        for (int c = 1; c <= 20000 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (en0 || en1) begin
                int ea = addrq.size() ? addrq.pop_front() : 'hDEAD;
                check("ram_addr", addr0, ea);
                check("ram_addr_lsb", addr1, ea);
            end
            if (hold) begin
                check("hold_dout", dout0, hd);
                check("hold_valid", valid0, 1);
                check("hold_en", en0, 0);
            end
            if (valid0 && first_valid < 0) first_valid = c;
            if (ready_mode == 1) ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 2) begin
                ready = stall >= 5;
                if (valid0) stall++;
            end
            if (valid0 && ready) begin
                check("byte_msb", dout0, q0.size() ? q0.pop_front() : 'h1FF);
                check("byte_lsb", dout1, q1.size() ? q1.pop_front() : 'h1FF);
            end
            hold = valid0 && !ready;
            hd = dout0;
            if (poke) begin
                start = (c == 3);
                base = 12'($urandom);
                nbytes = 10'd5;
            end
            if (done0 || done1) begin
                done_cyc = c;
                check("done_pair", {done0, done1}, 2'b11);
                check("done_bytes_left", q0.size(), 0);
                check("done_addr_left", addrq.size(), 0);
                check("done_busy", {busy0, busy1}, 0);
            end
        end
        if (done_cyc < 0) check("timeout", 0, 1);
    endtask

    initial begin
        logic [15:0] pat = 16'hA53C;
        int fv, dc, b;
        for (int i = 0; i < 4096; i++) mem[i] = 0;
        repeat (3) @(negedge clk);
        reset_outputs("reset");
        rst = 0;
        @(negedge clk);

        mem[0] = 1;
        run_cmd(0, 1, 0, 0, fv, dc);
        check("t1_first_valid", fv, 10);
        check("t1_done_cycle", dc, 11);
        check("t1_ref_msb", ref_byte(0, 1), 8'h80);
        check("t1_ref_lsb", ref_byte(0, 0), 8'h01);

        for (int j = 0; j < 16; j++) mem[j] = pat[15-j];
        @(negedge clk);
        run_cmd(0, 2, 2, 0, fv, dc);
        @(negedge clk);
        check("t2_single_done", {done0, busy0}, 0);

        for (int j = 0; j < 4; j++) begin mem[4092+j] = 1; mem[j] = 0; end
        run_cmd(4092, 1, 0, 0, fv, dc);
        check("wrap_ref", ref_byte(4092, 1), 8'hF0);

        run_cmd(123, 0, 0, 0, fv, dc);
        check("n0_done_cycle", dc, 1);
        check("n0_no_valid", fv, -1);

        for (int i = 0; i < 4096; i++) mem[i] = 1'($urandom);
        @(negedge clk);
        run_cmd(int'($urandom_range(0, 4095)), 2, 0, 1, fv, dc);
        check("poke_done_cycle", dc, 21);
        repeat (3) begin
            @(negedge clk);
            check("poke_idle", {busy0, done0, en0, valid0}, 0);
        end

        for (int k = 0; k < 8; k++)
            run_cmd(int'($urandom_range(0, 4095)), int'($urandom_range(0, 6)), 1, 0, fv, dc);
        run_cmd(int'($urandom_range(1, 4095)), 512, 0, 0, fv, dc);
        check("full_done_cycle", dc, 5121);

        @(negedge clk);
        b = int'($urandom_range(0, 4095));
        start = 1; base = 12'(b); nbytes = 10'd3; ready = 1;
        @(posedge clk); #1 start = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        reset_outputs("midrst");
        rst = 0;
        repeat (12) begin
            @(negedge clk);
            check("midrst_quiet", {done0, done1, en0, busy0, valid0}, 0);
        end
        run_cmd(int'($urandom_range(0, 4095)), 3, 1, 0, fv, dc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
